cmd_bus_master: RTL and testbench
=================================

CMD_BUS_MASTER -- requirements
Module: cmd_bus_master

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 16: clk cycles bus_c is stable with bus_clk high before each falling edge (>=1).
REQ-002 SHALL have parameter HOLD_CYC, default 16: clk cycles bus_clk stays low per symbol (>=1).
REQ-003 SHALL have parameter GAP_CYC, default 16: clk cycles bus_clk is high after each rising edge before the next symbol (>=1).
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  in  1  system clock; rstn  in  1  async reset, active low.
REQ-005 SHALL have cmd_valid  in  1: host command request.
REQ-006 SHALL have cmd_op  in  4: opcode; 0 PAUSE, 1 PLUS, 2 MINUS, 3 BALLAST_P, 4 BALLAST_N, 5 START, 6 SHUTDOWN, 7 DISCHARGE_1, 8 DISCHARGE_3; 9-15 invalid.
REQ-007 SHALL have cmd_ready  out  1: command accepted on a cycle where cmd_valid and cmd_ready are both high.
REQ-008 SHALL have shdn_req  in  1: safety shutdown request, level or pulse.
REQ-009 SHALL have shdn_ack  out  1: one-cycle pulse when the shutdown symbol completes.
REQ-010 SHALL have bus_c  out  3: command bus code.
REQ-011 SHALL have bus_clk  out  1: bus strobe; the receiver samples bus_c on the falling edge.
REQ-012 SHALL have busy, done and err  out  1 each: busy = sequence in progress; done = one-cycle pulse at the end of a host sequence; err = one-cycle pulse on an invalid opcode.

Function
REQ-013 SHALL emit these symbol sequences: ops 0-4 -> single symbol equal to op; START -> 5,0; SHUTDOWN -> 6; DISCHARGE_1 -> 7,0,7,0,1; DISCHARGE_3 -> 7,0,7,0,3.
REQ-014 SHALL implement the FSM IDLE -> SETUP -> LOW -> GAP -> (SETUP for the next symbol | IDLE).
- SETUP: bus_c = symbol, bus_clk = 1, SETUP_CYC cycles.
- LOW: bus_clk = 0, HOLD_CYC cycles.
- GAP: bus_clk = 1, GAP_CYC cycles.
REQ-015 SHALL hold bus_c at the current symbol through SETUP, LOW and GAP, and SHALL hold it at the last symbol in IDLE.
REQ-016 SHALL assert cmd_ready = (state == IDLE) and no shutdown is pending.
REQ-017 SHALL, for a command accepted in cycle T, drive bus_c in cycle T+1 and the first bus_clk falling edge in cycle T+1+SETUP_CYC.
REQ-018 SHALL take exactly SETUP_CYC+HOLD_CYC+GAP_CYC cycles per symbol.
REQ-019 SHALL pulse done in the last GAP cycle of a host sequence; cmd_ready SHALL rise in the following cycle.
REQ-020 SHALL, for an invalid opcode, accept it, pulse err in cycle T+1, produce no bus activity, and return to IDLE in cycle T+1.
REQ-021 SHALL latch shdn_req into a pending flag on any cycle, and SHALL clear the flag only when the SHUTDOWN symbol's GAP ends (same cycle as shdn_ack).
REQ-022 SHALL make shutdown non-preemptive: a sequence in progress completes all its symbols, then SHUTDOWN starts directly from IDLE on the next cycle.
REQ-023 SHALL give a pending shutdown priority over cmd_valid in IDLE.
REQ-024 SHALL treat shdn_req arriving during a SHUTDOWN symbol as already served (no second symbol).
REQ-025 SHALL hold busy high in every state except IDLE.
REQ-026 SHALL size the phase counter as $clog2(max(SETUP_CYC,HOLD_CYC,GAP_CYC)+1) bits, with no wrap-around; the counter loads on phase entry and counts down to 0.
REQ-027 SHALL size the symbol index as 3 bits (maximum 5 symbols).

Reset
REQ-028 SHALL, while rstn = 0 (asynchronously, including mid-sequence), force: state IDLE, bus_clk = 1, bus_c = 0, cmd_ready = 1, busy = done = err = shdn_ack = 0, shutdown pending = 0, counters = 0.
REQ-029 SHALL produce no bus_clk falling edge on reset entry or exit.

Structure
REQ-030 SHALL place the opcode enum, bus code constants (0-7) and the symbol-sequence lookup function in the shared package cmd_bus_pkg.
REQ-031 SHALL be a single module with no sub-module; the FSM SHALL use registered outputs in a single state struct.

Verification (defaults 16/16/16)
REQ-032 SHALL cover: PLUS accepted at T -> bus_c = 1 at T+1, bus_clk low T+17..T+32, done at T+48, cmd_ready high at T+49.
REQ-033 SHALL cover: DISCHARGE_3 -> falling edges with bus_c 7,0,7,0,3, 48 cycles apart; done 240 cycles after accept.
REQ-034 SHALL cover: shdn_req pulse during symbol 5 of START -> symbol 0 completes, then symbol 6; shdn_ack one cycle; cmd_ready low throughout.
REQ-035 SHALL cover: cmd_valid and shdn_req together in IDLE -> SHUTDOWN sent first, host command accepted after shdn_ack.
REQ-036 SHALL cover: cmd_op = 12 -> err pulse, no bus_clk edge, cmd_ready high again after one cycle.
REQ-037 SHALL cover: rstn low during the LOW phase -> bus_clk = 1 and bus_c = 0 immediately; after release a PLUS command completes normally.

Source files
------------

// File: rtl/cmd_bus_pkg.sv
// Opcodes, bus codes, FSM states and symbol lookup
// shared by the command bus master and its bench.
package cmd_bus_pkg;

  typedef enum logic [3:0] {
    OP_PAUSE       = 4'd0,
    OP_PLUS        = 4'd1,
    OP_MINUS       = 4'd2,
    OP_BALLAST_P   = 4'd3,
    OP_BALLAST_N   = 4'd4,
    OP_START       = 4'd5,
    OP_SHUTDOWN    = 4'd6,
    OP_DISCHARGE_1 = 4'd7,
    OP_DISCHARGE_3 = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_LOW,
    S_GAP
  } state_e;

  localparam logic [2:0] BC_PAUSE     = 3'd0;
  localparam logic [2:0] BC_PLUS      = 3'd1;
  localparam logic [2:0] BC_MINUS     = 3'd2;
  localparam logic [2:0] BC_BALLAST_P = 3'd3;
  localparam logic [2:0] BC_BALLAST_N = 3'd4;
  localparam logic [2:0] BC_START     = 3'd5;
  localparam logic [2:0] BC_SHUTDOWN  = 3'd6;
  localparam logic [2:0] BC_DISCHARGE = 3'd7;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic op_valid(logic [3:0] op);
    return op <= OP_DISCHARGE_3;
  endfunction

  function automatic logic [2:0] seq_len(logic [3:0] op);
    logic [2:0] n;
    n = 3'd1;
    if (op == OP_START)
      n = 3'd2;
    else if (op == OP_DISCHARGE_1 || op == OP_DISCHARGE_3)
      n = 3'd5;
    return n;
  endfunction

  // Discharge sequences are 7,0,7,0 followed by the
  // discharge count (1 or 3) as the final symbol.
  function automatic logic [2:0] seq_sym(logic [3:0] op,
                                         logic [2:0] idx);
    logic [2:0] s;
    s = BC_PAUSE;
    unique case (1'b1)
      op == OP_PLUS:      s = BC_PLUS;
      op == OP_MINUS:     s = BC_MINUS;
      op == OP_BALLAST_P: s = BC_BALLAST_P;
      op == OP_BALLAST_N: s = BC_BALLAST_N;
      op == OP_SHUTDOWN:  s = BC_SHUTDOWN;
      op == OP_START:
        s = (idx == 3'd0) ? BC_START : BC_PAUSE;
      op == OP_DISCHARGE_1,
      op == OP_DISCHARGE_3: begin
        if (idx == 3'd4)
          s = (op == OP_DISCHARGE_1) ? BC_PLUS : BC_BALLAST_P;
        else
          s = idx[0] ? BC_PAUSE : BC_DISCHARGE;
      end
      default: s = BC_PAUSE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cmd_bus_master_if.sv
// Host command handshake, shutdown request and bus pins.
// master: the bus master side; slave: host/bus side.
interface cmd_bus_master_if;
  logic       cmd_valid;
  logic [3:0] cmd_op;
  logic       cmd_ready;
  logic       shdn_req;
  logic       shdn_ack;
  logic [2:0] bus_c;
  logic       bus_clk;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    input  cmd_valid, cmd_op, shdn_req,
    output cmd_ready, shdn_ack, bus_c, bus_clk,
    output busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_op, shdn_req,
    input  cmd_ready, shdn_ack, bus_c, bus_clk,
    input  busy, done, err
  );
endinterface

// File: rtl/cmd_bus_master.sv
// Serialises host opcodes into bus_c/bus_clk symbols,
// with a non-preemptive safety shutdown path.
// Ports: clk, rstn (async, low), bus (master modport).
module cmd_bus_master
  import cmd_bus_pkg::*;
#(
  parameter int SETUP_CYC = 16,
  parameter int HOLD_CYC  = 16,
  parameter int GAP_CYC   = 16
) (
  input  logic clk,
  input  logic rstn,
  cmd_bus_master_if.master bus
);

  localparam int MAXC = max3(SETUP_CYC, HOLD_CYC, GAP_CYC);
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef struct packed {
    state_e      st;
    logic [CW-1:0] cnt;
    logic [2:0]  idx;
    logic [3:0]  op;
    logic        safety;
    logic        pend;
    logic [2:0]  c;
    logic        bclk;
    logic        done;
    logic        err;
    logic        ack;
  } regs_t;

  localparam regs_t RST_VAL = '{
    st:     S_IDLE,
    cnt:    '0,
    idx:    3'd0,
    op:     4'd0,
    safety: 1'b0,
    pend:   1'b0,
    c:      BC_PAUSE,
    bclk:   1'b1,
    done:   1'b0,
    err:    1'b0,
    ack:    1'b0
  };

  regs_t r;
  regs_t n;
  logic  end_phase;
  logic  last_sym;
  logic  n_last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r <= RST_VAL;
    else
      r <= n;
  end

  always_comb begin
    n = r;
    n.done = 1'b0;
    n.err  = 1'b0;
    n.ack  = 1'b0;
    // A request is remembered whatever the FSM is doing.
    n.pend = r.pend | bus.shdn_req;
    end_phase = (r.cnt == '0);
    last_sym  = (r.idx == seq_len(r.op) - 3'd1);

    unique case (r.st)
      S_IDLE: begin
        if (n.pend) begin
          n.st     = S_SETUP;
          n.op     = OP_SHUTDOWN;
          n.safety = 1'b1;
          n.idx    = 3'd0;
          n.cnt    = SETUP_LD;
          n.c      = BC_SHUTDOWN;
        end else if (bus.cmd_valid) begin
          if (op_valid(bus.cmd_op)) begin
            n.st     = S_SETUP;
            n.op     = bus.cmd_op;
            n.safety = 1'b0;
            n.idx    = 3'd0;
            n.cnt    = SETUP_LD;
            n.c      = seq_sym(bus.cmd_op, 3'd0);
          end else begin
            n.err = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (end_phase) begin
          n.st   = S_LOW;
          n.cnt  = HOLD_LD;
          n.bclk = 1'b0;
        end else begin
          n.cnt = r.cnt - ONE;
        end
      end
      S_LOW: begin
        if (end_phase) begin
          n.st   = S_GAP;
          n.cnt  = GAP_LD;
          n.bclk = 1'b1;
        end else begin
          n.cnt = r.cnt - ONE;
        end
      end
      S_GAP: begin
        if (end_phase) begin
          // Any shutdown symbol on the bus serves requests
          // that arrived while it was being sent.
          if (r.c == BC_SHUTDOWN)
            n.pend = 1'b0;
          if (last_sym) begin
            n.st     = S_IDLE;
            n.safety = 1'b0;
          end else begin
            n.st  = S_SETUP;
            n.idx = r.idx + 3'd1;
            n.cnt = SETUP_LD;
            n.c   = seq_sym(r.op, r.idx + 3'd1);
          end
        end else begin
          n.cnt = r.cnt - ONE;
        end
      end
      default: n = RST_VAL;
    endcase

    // Pulses are registered so they land on the final
    // GAP cycle of the sequence.
    n_last = (n.idx == seq_len(n.op) - 3'd1);
    if (n.st == S_GAP && n.cnt == '0) begin
      if (n_last && !n.safety)
        n.done = 1'b1;
      if (n.c == BC_SHUTDOWN && (n.safety || n.pend))
        n.ack = 1'b1;
    end
  end

  assign bus.bus_c    = r.c;
  assign bus.bus_clk  = r.bclk;
  assign bus.busy     = (r.st != S_IDLE);
  assign bus.done     = r.done;
  assign bus.err      = r.err;
  assign bus.shdn_ack = r.ack;
  // A live request blocks the host in the same cycle.
  assign bus.cmd_ready = ~rstn |
    ((r.st == S_IDLE) & ~r.pend & ~bus.shdn_req);

endmodule

// File: tb/tb_cmd_bus_master.sv
// Directed bench for cmd_bus_master with a cycle-stamped
// scoreboard of bus edges, done, err and shdn_ack pulses.
module tb_cmd_bus_master;
  import cmd_bus_pkg::*;

  localparam int SU  = 16;
  localparam int HO  = 16;
  localparam int GA  = 16;
  localparam int SYM = SU + HO + GA;

  typedef struct {
    int cyc;
    int code;
  } fall_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  logic prev_bclk = 1'b1;

  fall_t exp_fall[$];
  int    exp_rise[$];
  int    exp_done[$];
  int    exp_err[$];
  int    exp_ack[$];
  fall_t mf;
  int    mi;

  cmd_bus_master_if bus_if ();

  cmd_bus_master #(
    .SETUP_CYC(SU),
    .HOLD_CYC (HO),
    .GAP_CYC  (GA)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic int tb_len(int op);
    if (op == 5) return 2;
    if (op == 7 || op == 8) return 5;
    return 1;
  endfunction

  function automatic int tb_sym(int op, int i);
    if (op == 5) return (i == 0) ? 5 : 0;
    if (op == 7 || op == 8) begin
      if (i == 4) return (op == 7) ? 1 : 3;
      return (i % 2 == 0) ? 7 : 0;
    end
    return op;
  endfunction

  // t0: cycle in which the FSM leaves IDLE is t0+1.
  task automatic push_seq(int t0, int op, bit host);
    fall_t f;
    int len;
    len = tb_len(op);
    for (int i = 0; i < len; i++) begin
      f.cyc  = t0 + 1 + SU + i * SYM;
      f.code = tb_sym(op, i);
      exp_fall.push_back(f);
      exp_rise.push_back(f.cyc + HO);
    end
    if (host) exp_done.push_back(t0 + len * SYM);
    else      exp_ack.push_back(t0 + len * SYM);
  endtask

  task automatic send(int op, output int t);
    bit ok;
    ok = 1'b0;
    t  = -1;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = 4'(op);
    for (int k = 0; k < 2000; k++) begin
      #1;
      if (bus_if.cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("send_timeout", 32'd1, 32'd0);
    end else begin
      t = cyc;
      if (op <= 8) push_seq(t, op, 1'b1);
      else         exp_err.push_back(t + 1);
    end
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_to(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!bus_if.busy && bus_if.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 32'd1, 32'd0);
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (prev_bclk && !bus_if.bus_clk) begin
        if (exp_fall.size() == 0) begin
          check("unexpected_fall", 32'd1, 32'd0);
        end else begin
          mf = exp_fall.pop_front();
          check("fall_code", 32'(bus_if.bus_c), mf.code);
          check("fall_cyc", cyc, mf.cyc);
        end
      end
      if (!prev_bclk && bus_if.bus_clk) begin
        if (exp_rise.size() == 0) begin
          check("unexpected_rise", 32'd1, 32'd0);
        end else begin
          mi = exp_rise.pop_front();
          check("rise_cyc", cyc, mi);
        end
      end
      if (bus_if.done) begin
        if (exp_done.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          mi = exp_done.pop_front();
          check("done_cyc", cyc, mi);
        end
      end
      if (bus_if.err) begin
        if (exp_err.size() == 0) begin
          check("unexpected_err", 32'd1, 32'd0);
        end else begin
          mi = exp_err.pop_front();
          check("err_cyc", cyc, mi);
        end
      end
      if (bus_if.shdn_ack) begin
        if (exp_ack.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          mi = exp_ack.pop_front();
          check("ack_cyc", cyc, mi);
        end
      end
    end
    prev_bclk = bus_if.bus_clk;
  end

  initial begin
    int t;
    int t0;
    int ops[6];

    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_op    = 4'd0;
    bus_if.shdn_req  = 1'b0;
    ops = '{2, 4, 7, 5, 0, 6};

    // Reset values.
    repeat (2) @(negedge clk);
    #1;
    check("rst_bus_clk", 32'(bus_if.bus_clk), 32'd1);
    check("rst_bus_c", 32'(bus_if.bus_c), 32'd0);
    check("rst_ready", 32'(bus_if.cmd_ready), 32'd1);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_done", 32'(bus_if.done), 32'd0);
    check("rst_err", 32'(bus_if.err), 32'd0);
    check("rst_ack", 32'(bus_if.shdn_ack), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // PLUS timing.
    send(1, t);
    wait_to(t + 1);
    check("plus_c_t1", 32'(bus_if.bus_c), 32'd1);
    check("plus_busy", 32'(bus_if.busy), 32'd1);
    check("plus_setup_clk", 32'(bus_if.bus_clk), 32'd1);
    wait_to(t + 16);
    check("plus_clk_t16", 32'(bus_if.bus_clk), 32'd1);
    wait_to(t + 17);
    check("plus_clk_t17", 32'(bus_if.bus_clk), 32'd0);
    wait_to(t + 32);
    check("plus_clk_t32", 32'(bus_if.bus_clk), 32'd0);
    wait_to(t + 33);
    check("plus_clk_t33", 32'(bus_if.bus_clk), 32'd1);
    wait_to(t + 48);
    check("plus_done_t48", 32'(bus_if.done), 32'd1);
    check("plus_rdy_t48", 32'(bus_if.cmd_ready), 32'd0);
    wait_to(t + 49);
    check("plus_rdy_t49", 32'(bus_if.cmd_ready), 32'd1);
    check("plus_busy_t49", 32'(bus_if.busy), 32'd0);
    check("plus_c_hold", 32'(bus_if.bus_c), 32'd1);

    // DISCHARGE_3 and last-symbol hold in IDLE.
    send(8, t);
    wait_idle();
    check("dis3_len", cyc, t + 5 * SYM + 1);
    check("dis3_c_hold", 32'(bus_if.bus_c), 32'd3);

    // Other opcodes back to back.
    for (int i = 0; i < 6; i++) begin
      send(ops[i], t);
      wait_idle();
      check("op_c_hold", 32'(bus_if.bus_c),
            tb_sym(ops[i], tb_len(ops[i]) - 1));
    end

    // Invalid opcode.
    send(12, t);
    check("inv_ready_t1", 32'(bus_if.cmd_ready), 32'd1);
    check("inv_busy_t1", 32'(bus_if.busy), 32'd0);
    check("inv_clk_t1", 32'(bus_if.bus_clk), 32'd1);
    repeat (60) @(negedge clk);

    // Shutdown pulse during START symbol 5.
    send(5, t);
    wait_to(t + 10);
    bus_if.shdn_req = 1'b1;
    @(negedge clk);
    bus_if.shdn_req = 1'b0;
    push_seq(t + 2 * SYM + 1, 6, 1'b0);
    while (cyc <= t + 2 * SYM + 1 + SYM) begin
      check("shdn_rdy_low", 32'(bus_if.cmd_ready), 32'd0);
      @(negedge clk);
    end
    check("shdn_rdy_high", 32'(bus_if.cmd_ready), 32'd1);
    repeat (3) @(negedge clk);

    // Shutdown and host command together in IDLE.
    bus_if.shdn_req  = 1'b1;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = 4'd1;
    t0 = cyc;
    push_seq(t0, 6, 1'b0);
    #1;
    check("both_rdy_low", 32'(bus_if.cmd_ready), 32'd0);
    @(negedge clk);
    bus_if.shdn_req = 1'b0;
    send(1, t);
    check("both_accept_cyc", t, t0 + SYM + 1);
    wait_idle();

    // Reset during LOW, then a clean PLUS.
    send(1, t);
    wait_to(t + 20);
    check("mid_low_clk", 32'(bus_if.bus_clk), 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_clk", 32'(bus_if.bus_clk), 32'd1);
    check("mid_rst_c", 32'(bus_if.bus_c), 32'd0);
    check("mid_rst_rdy", 32'(bus_if.cmd_ready), 32'd1);
    check("mid_rst_busy", 32'(bus_if.busy), 32'd0);
    exp_rise.delete();
    exp_done.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    send(1, t);
    wait_idle();
    check("post_rst_c", 32'(bus_if.bus_c), 32'd1);

    repeat (5) @(negedge clk);
    check("left_fall", exp_fall.size(), 32'd0);
    check("left_rise", exp_rise.size(), 32'd0);
    check("left_done", exp_done.size(), 32'd0);
    check("left_err", exp_err.size(), 32'd0);
    check("left_ack", exp_ack.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
